fp_acc32: RTL and testbench

IEEE-754 single-precision streaming accumulator that sits directly downstream of the FP32 multiplier and sums its products into one dot-product result. It accepts one FP32 term per handshake and adds it into an internal accumulator through a multi-cycle add FSM (align, add, normalize, round). On the term flagged `in_last` it presents the final sum, then clears for the next vector. Special-value and flush rules match the multiplier, so a mult → acc chain has uniform semantics.

---
 rtl/fp_acc32.sv | 262 ++++++++++++++++++++++++++
 tb/tb_fp_acc32.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_acc32.sv
// fp_acc32: FP32 streaming accumulator. Each accepted term is added into acc through
// a serial ALIGN -> ADD -> NORM -> ROUND sequence; the term flagged last publishes
// the sum and clears acc. Subnormals flush to zero, NaN is canonical 0xFFC00000.
module fp_acc32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic [31:0] sum,
    output logic        sum_valid,
    output logic        busy
);

    typedef enum logic [2:0] {
        StIdle,
        StAlign,
        StAdd,
        StNorm,
        StRound,
        StDone
    } state_e;

    localparam logic [31:0] QNaN = 32'hFFC0_0000;

    state_e             state_q, state_d;
    logic [31:0]        acc_q, acc_d;
    logic [31:0]        t_q, t_d;
    logic               last_q, last_d;
    logic [31:0]        sum_q, sum_d;
    logic               sign_q, sign_d;
    logic               sub_q, sub_d;
    logic signed [9:0]  exp_q, exp_d;
    logic [26:0]        a_ext_q, a_ext_d;
    logic [26:0]        b_sh_q, b_sh_d;
    logic [27:0]        add_q, add_d;
    logic [26:0]        norm_q, norm_d;
    logic               zero_q, zero_d;
    logic               spec_q, spec_d;
    logic [31:0]        spec_val_q, spec_val_d;

    // Align-stage signals
    logic [7:0]         x_e, y_e, a_e, b_e, diff;
    logic [22:0]        x_m, y_m, a_m, b_m;
    logic               x_nan, y_nan, x_inf, y_inf, swap, a_s, b_s;
    logic [4:0]         sh;
    logic [53:0]        b_wide;
    logic [26:0]        b_sh;
    logic signed [9:0]  align_exp;
    logic               spec;
    logic [31:0]        spec_val;

    // Add / norm / round signals
    logic [27:0]        add_res;
    logic [4:0]         lz;
    logic [26:0]        norm_m;
    logic signed [9:0]  norm_e;
    logic               norm_z;
    logic [23:0]        m24;
    logic               rnd_up;
    logic [24:0]        m25;
    logic [23:0]        rnd_m;
    logic signed [9:0]  rnd_e;
    logic [7:0]         biased;
    logic [31:0]        result;

    // Leading-zero count of a 27-bit mantissa field (hidden bit at position 26)
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic       found;
        logic [4:0] cnt;
        found = 1'b0;
        cnt   = 5'd0;
        for (int i = 26; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      cnt   = cnt + 5'd1;
            end
        end
        return cnt;
    endfunction

    // Unpack acc and term, order by magnitude, shift the smaller one with sticky
    always_comb begin
        x_e   = acc_q[30:23];
        y_e   = t_q[30:23];
        x_m   = (x_e == 8'd0) ? 23'd0 : acc_q[22:0];
        y_m   = (y_e == 8'd0) ? 23'd0 : t_q[22:0];
        x_nan = (x_e == 8'hFF) && (x_m != 23'd0);
        y_nan = (y_e == 8'hFF) && (y_m != 23'd0);
        x_inf = (x_e == 8'hFF) && (x_m == 23'd0);
        y_inf = (y_e == 8'hFF) && (y_m == 23'd0);
        swap  = {y_e, y_m} > {x_e, x_m};
        a_s   = swap ? t_q[31] : acc_q[31];
        a_e   = swap ? y_e : x_e;
        a_m   = swap ? y_m : x_m;
        b_s   = swap ? acc_q[31] : t_q[31];
        b_e   = swap ? x_e : y_e;
        b_m   = swap ? x_m : y_m;
        diff  = a_e - b_e;
        sh    = (diff > 8'd27) ? 5'd27 : diff[4:0];
        b_wide = {(b_e != 8'd0), b_m, 3'b000, 27'd0} >> sh;
        b_sh  = {b_wide[53:28], b_wide[27] | (|b_wide[26:0])};
        align_exp = $signed({2'b00, a_e}) - 10'sd127;
        spec  = x_nan | y_nan | x_inf | y_inf;
        if (x_nan || y_nan || (x_inf && y_inf && (acc_q[31] != t_q[31]))) begin
            spec_val = QNaN;
        end else if (x_inf) begin
            spec_val = {acc_q[31], 31'h7F80_0000};
        end else begin
            spec_val = {t_q[31], 31'h7F80_0000};
        end
    end

    // Magnitude add or subtract; A >= B so the difference never goes negative
    always_comb begin
        if (sub_q) add_res = {1'b0, a_ext_q} - {1'b0, b_sh_q};
        else       add_res = {1'b0, a_ext_q} + {1'b0, b_sh_q};
    end

    // Normalize: carry shifts right keeping sticky, otherwise shift out leading zeros
    always_comb begin
        lz     = lzc27(add_q[26:0]);
        norm_m = add_q[26:0];
        norm_e = exp_q;
        norm_z = 1'b0;
        if (add_q[27]) begin
            norm_m = {add_q[27:2], add_q[1] | add_q[0]};
            norm_e = exp_q + 10'sd1;
        end else if (add_q[26:0] == 27'd0) begin
            norm_z = 1'b1;
        end else begin
            norm_m = add_q[26:0] << lz;
            norm_e = exp_q - $signed({5'd0, lz});
        end
    end

    // Round to nearest even, then apply special / overflow / flush rules
    always_comb begin
        m24    = norm_q[26:3];
        rnd_up = norm_q[2] & (norm_q[1] | norm_q[0] | m24[0]);
        m25    = {1'b0, m24} + {24'd0, rnd_up};
        if (m25[24]) begin
            rnd_m = m25[24:1];
            rnd_e = exp_q + 10'sd1;
        end else begin
            rnd_m = m25[23:0];
            rnd_e = exp_q;
        end
        biased = rnd_e[7:0] + 8'd127;
        if (spec_q)                  result = spec_val_q;
        else if (zero_q)             result = 32'd0;
        else if (rnd_e > 10'sd127)   result = {sign_q, 31'h7F80_0000};
        else if (rnd_e < -10'sd126)  result = 32'd0;
        else                         result = {sign_q, biased, rnd_m[22:0]};
    end

    // Next-state: sequence the add stages and route each stage into its registers
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        t_d        = t_q;
        last_d     = last_q;
        sum_d      = sum_q;
        sign_d     = sign_q;
        sub_d      = sub_q;
        exp_d      = exp_q;
        a_ext_d    = a_ext_q;
        b_sh_d     = b_sh_q;
        add_d      = add_q;
        norm_d     = norm_q;
        zero_d     = zero_q;
        spec_d     = spec_q;
        spec_val_d = spec_val_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    t_d     = in_data;
                    last_d  = in_last;
                    state_d = StAlign;
                end
            end
            StAlign: begin
                sign_d     = a_s;
                sub_d      = a_s ^ b_s;
                exp_d      = align_exp;
                a_ext_d    = {(a_e != 8'd0), a_m, 3'b000};
                b_sh_d     = b_sh;
                spec_d     = spec;
                spec_val_d = spec_val;
                state_d    = StAdd;
            end
            StAdd: begin
                add_d   = add_res;
                state_d = StNorm;
            end
            StNorm: begin
                norm_d  = norm_m;
                exp_d   = norm_e;
                zero_d  = norm_z;
                state_d = StRound;
            end
            StRound: begin
                acc_d = result;
                if (last_q) begin
                    sum_d   = result;
                    state_d = StDone;
                end else begin
                    state_d = StIdle;
                end
            end
            StDone: begin
                acc_d   = 32'd0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            acc_q      <= 32'd0;
            t_q        <= 32'd0;
            last_q     <= 1'b0;
            sum_q      <= 32'd0;
            sign_q     <= 1'b0;
            sub_q      <= 1'b0;
            exp_q      <= 10'sd0;
            a_ext_q    <= 27'd0;
            b_sh_q     <= 27'd0;
            add_q      <= 28'd0;
            norm_q     <= 27'd0;
            zero_q     <= 1'b0;
            spec_q     <= 1'b0;
            spec_val_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            t_q        <= t_d;
            last_q     <= last_d;
            sum_q      <= sum_d;
            sign_q     <= sign_d;
            sub_q      <= sub_d;
            exp_q      <= exp_d;
            a_ext_q    <= a_ext_d;
            b_sh_q     <= b_sh_d;
            add_q      <= add_d;
            norm_q     <= norm_d;
            zero_q     <= zero_d;
            spec_q     <= spec_d;
            spec_val_q <= spec_val_d;
        end
    end

    assign in_ready  = (state_q == StIdle) && !rst;
    assign busy      = (state_q != StIdle);
    assign sum_valid = (state_q == StDone);
    assign sum       = sum_q;

endmodule

// File: tb/tb_fp_acc32.sv
// tb_fp_acc32: scenario tasks drive terms, push expected sums to a scoreboard queue
// and pop/compare them when sum_valid pulses.
module tb_fp_acc32;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        in_ready;
    logic [31:0] sum;
    logic        sum_valid;
    logic        busy;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [31:0] sb[$];

    fp_acc32 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .sum       (sum),
        .sum_valid (sum_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    // Advance one clock and sample 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a term and wait (bounded) for it to be accepted; returns in ALIGN
    task automatic drive_term(input logic [31:0] d, input logic last, output logic ok);
        int w;
        w        = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && w < 50) begin
            step();
            w++;
        end
        ok = in_ready;
        if (ok) step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Wait for a sum_valid pulse; lat counts samples after the one following acceptance
    task automatic wait_pulse(input int budget, output logic got, output logic [31:0] val,
                              output int lat);
        got = 1'b0;
        val = 32'd0;
        lat = 0;
        for (int i = 1; i <= budget && !got; i++) begin
            step();
            if (sum_valid) begin
                got = 1'b1;
                val = sum;
                lat = i;
            end
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 32'd0;
        in_last  = 1'b0;
        step();
        step();
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b expected 0", in_ready);
        end
        n_vec++;
        if (busy !== 1'b0 || sum_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: got busy=%b sum_valid=%b expected 0/0", busy, sum_valid);
        end
        n_vec++;
        if (sum !== 32'd0) begin
            n_err++;
            $display("FAIL reset_sum: got %h expected 00000000", sum);
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_ready: got %b expected 1", in_ready);
        end
    endtask

    // 1 + 2 + 3 with per-term in_ready and pulse timing
    task automatic test_basic();
        logic [31:0] terms[3];
        logic        ok, got;
        logic [31:0] val, exp_v;
        int          lows, lat;
        terms[0] = 32'h3F80_0000;
        terms[1] = 32'h4000_0000;
        terms[2] = 32'h4040_0000;
        for (int k = 0; k < 2; k++) begin
            drive_term(terms[k], 1'b0, ok);
            lows = 0;
            while (!in_ready && lows < 20) begin
                lows++;
                step();
            end
            n_vec++;
            if (!ok || lows != 4) begin
                n_err++;
                $display("FAIL basic_ready_low[%0d]: got ok=%b low=%0d expected ok=1 low=4",
                         k, ok, lows);
            end
        end
        sb.push_back(32'h40C0_0000);
        drive_term(terms[2], 1'b1, ok);
        wait_pulse(20, got, val, lat);
        exp_v = sb.pop_front();
        n_vec++;
        if (!ok || !got || lat != 4) begin
            n_err++;
            $display("FAIL basic_latency: got ok=%b pulse=%b lat=%0d expected 1/1/4", ok, got, lat);
        end
        n_vec++;
        if (val !== exp_v) begin
            n_err++;
            $display("FAIL basic_sum: got %h expected %h", val, exp_v);
        end
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL basic_done_ready: got %b expected 0", in_ready);
        end
        step();
        n_vec++;
        if (sum_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 32'h40C0_0000) begin
            n_err++;
            $display("FAIL basic_after_done: got sv=%b rdy=%b sum=%h expected 0/1/40c00000",
                     sum_valid, in_ready, sum);
        end
    endtask

    // Two-term vectors covering rounding and special values
    task automatic test_specials();
        logic [31:0] va[10], vb[10], ve[10];
        logic        ok0, ok1, got;
        logic [31:0] val, exp_v;
        int          lat;
        va[0] = 32'h3F80_0000; vb[0] = 32'h3380_0000; ve[0] = 32'h3F80_0000;
        va[1] = 32'h3F80_0000; vb[1] = 32'h3380_0001; ve[1] = 32'h3F80_0001;
        va[2] = 32'h7F80_0000; vb[2] = 32'hFF80_0000; ve[2] = 32'hFFC0_0000;
        va[3] = 32'h7F7F_FFFF; vb[3] = 32'h7F7F_FFFF; ve[3] = 32'h7F80_0000;
        va[4] = 32'h4049_0FDB; vb[4] = 32'hC049_0FDB; ve[4] = 32'h0000_0000;
        va[5] = 32'h0000_0001; vb[5] = 32'h8080_0000; ve[5] = 32'h8080_0000;
        va[6] = 32'h7FC0_0001; vb[6] = 32'h3F80_0000; ve[6] = 32'hFFC0_0000;
        va[7] = 32'hFF80_0000; vb[7] = 32'h4000_0000; ve[7] = 32'hFF80_0000;
        va[8] = 32'hFF7F_FFFF; vb[8] = 32'hFF7F_FFFF; ve[8] = 32'hFF80_0000;
        va[9] = 32'h0080_0001; vb[9] = 32'h8080_0000; ve[9] = 32'h0000_0000;
        for (int k = 0; k < 10; k++) begin
            drive_term(va[k], 1'b0, ok0);
            sb.push_back(ve[k]);
            drive_term(vb[k], 1'b1, ok1);
            wait_pulse(20, got, val, lat);
            exp_v = sb.pop_front();
            n_vec++;
            if (!ok0 || !ok1 || !got || val !== exp_v) begin
                n_err++;
                $display("FAIL special[%0d] %h+%h: got %h (pulse=%b) expected %h",
                         k, va[k], vb[k], val, got, exp_v);
            end
        end
    endtask

    // Reset during NORM of the second term discards the vector
    task automatic test_reset_abort();
        logic        ok0, ok1, ok2, got;
        logic [31:0] val, exp_v;
        int          lat, pulses, w;
        drive_term(32'h3F80_0000, 1'b0, ok0);
        drive_term(32'h4000_0000, 1'b0, ok1);
        step();
        step();
        rst = 1'b1;
        step();
        n_vec++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL abort_in_reset: got busy=%b rdy=%b expected 0/0", busy, in_ready);
        end
        rst    = 1'b0;
        pulses = 0;
        for (w = 0; w < 10; w++) begin
            if (sum_valid) pulses++;
            step();
        end
        n_vec++;
        if (!ok0 || !ok1 || pulses != 0) begin
            n_err++;
            $display("FAIL abort_no_pulse: got pulses=%0d ok=%b%b expected 0", pulses, ok0, ok1);
        end
        sb.push_back(32'h3F80_0000);
        drive_term(32'h3F80_0000, 1'b1, ok2);
        wait_pulse(20, got, val, lat);
        exp_v = sb.pop_front();
        n_vec++;
        if (!ok2 || !got || val !== exp_v) begin
            n_err++;
            $display("FAIL abort_next_sum: got %h (pulse=%b) expected %h", val, got, exp_v);
        end
    endtask

    // in_valid held high for 8 terms, then back-to-back single-term vectors
    task automatic test_back_to_back();
        logic        ok, got;
        logic [31:0] val, exp_v;
        int          accepts, first_cyc, last_cyc, lat, w;
        accepts   = 0;
        first_cyc = 0;
        last_cyc  = 0;
        in_valid  = 1'b1;
        in_data   = 32'h3F80_0000;
        for (w = 0; w < 100 && accepts < 8; w++) begin
            in_last = (accepts == 7);
            if (in_ready) begin
                if (accepts == 0) first_cyc = cyc;
                last_cyc = cyc;
                accepts++;
            end
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        sb.push_back(32'h4100_0000);
        n_vec++;
        if (accepts != 8 || (last_cyc - first_cyc) != 35) begin
            n_err++;
            $display("FAIL stream_rate: got accepts=%0d span=%0d expected 8/35",
                     accepts, last_cyc - first_cyc);
        end
        wait_pulse(20, got, val, lat);
        exp_v = sb.pop_front();
        n_vec++;
        if (!got || lat != 4 || val !== exp_v) begin
            n_err++;
            $display("FAIL stream_sum: got %h (pulse=%b lat=%0d) expected %h lat=4",
                     val, got, lat, exp_v);
        end
        step();
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_ready_t6: got %b expected 1", in_ready);
        end
        sb.push_back(32'h4040_0000);
        drive_term(32'h4040_0000, 1'b1, ok);
        wait_pulse(20, got, val, lat);
        exp_v = sb.pop_front();
        n_vec++;
        if (!ok || !got || val !== exp_v) begin
            n_err++;
            $display("FAIL b2b_fresh_sum: got %h (pulse=%b) expected %h", val, got, exp_v);
        end
        step();
        sb.push_back(32'h0000_0000);
        drive_term(32'h807F_FFFF, 1'b1, ok);
        wait_pulse(20, got, val, lat);
        exp_v = sb.pop_front();
        n_vec++;
        if (!ok || !got || val !== exp_v) begin
            n_err++;
            $display("FAIL single_subnormal: got %h (pulse=%b) expected %h", val, got, exp_v);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_specials();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
